// File: rtl/wb_inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: line width, filler word and FSM states.
package wb_inst_sequencer_pkg;

    localparam int          LINE_W       = 128;
    localparam logic [31:0] NOP_INST_DEF = 32'hF0801003;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACK       = 2'd1,
        ST_WAIT_RES  = 2'd2,
        ST_DRAIN_CHK = 2'd3
    } seq_state_t;

    // Builds a fetch line with the served word in the low lane and filler above it.
    function automatic logic [LINE_W-1:0] fetch_line(input logic [31:0] word, input logic [31:0] nop);
        return {nop, nop, nop, word};
    endfunction

endpackage

// File: rtl/wb_inst_fifo.sv
// Instruction queue: power-of-two circular buffer with push/pop, full/empty and occupancy count.
module wb_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_inst_sequencer.sv
// Serves queued instructions to a core over Wishbone reads and captures core writes into a result slot.
// state     | meaning
// IDLE      | samples new requests and drain pulses
// ACK       | one-cycle ack (or error) response, then back to IDLE
// WAIT_RES  | write held until the result slot frees or the strobe drops
// DRAIN_CHK | one settle cycle after a drain pulse seen with no request pending
module wb_inst_sequencer
    import wb_inst_sequencer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF,
    parameter int          DRAIN_NOPS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inst_valid,
    input  logic [31:0]       i_inst,
    output logic              o_inst_ready,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_adr,
    input  logic [15:0]       i_wb_sel,
    input  logic [LINE_W-1:0] i_wb_dat,
    output logic [LINE_W-1:0] o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [31:0]       o_res_adr,
    output logic [15:0]       o_res_sel,
    output logic [LINE_W-1:0] o_res_data,
    input  logic              i_drain,
    output logic              o_busy,
    output logic [31:0]       o_fetch_pc
);
    localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_NOPS);
    localparam logic [LINE_W-1:0] NOP_LINE   = {4{NOP_INST}};

    seq_state_t                  r_state;
    logic [7:0]                  r_drain_cnt;
    logic                        r_wb_ack;
    logic                        r_wb_err;
    logic [LINE_W-1:0]           r_wb_dat;
    logic                        r_res_valid;
    logic [31:0]                 r_res_adr;
    logic [15:0]                 r_res_sel;
    logic [LINE_W-1:0]           r_res_data;
    logic [31:0]                 r_fetch_pc;

    logic                        w_req;
    logic                        w_serve_inst;
    logic                        w_pop;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [31:0]                 w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_req        = i_wb_cyc && i_wb_stb;
    assign w_serve_inst = !w_fifo_empty && (r_drain_cnt == 8'd0);
    assign w_pop        = (r_state == ST_IDLE) && w_req && !i_wb_we && w_serve_inst;

    wb_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_inst_valid && o_inst_ready),
        .i_data  (i_inst),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 8'd0;
            r_wb_ack    <= 1'b0;
            r_wb_err    <= 1'b0;
            r_wb_dat    <= NOP_LINE;
            r_res_valid <= 1'b0;
            r_res_adr   <= '0;
            r_res_sel   <= '0;
            r_res_data  <= '0;
            r_fetch_pc  <= '0;
        end else begin
            r_wb_ack <= 1'b0;
            r_wb_err <= 1'b0;
            r_wb_dat <= NOP_LINE;
            if (r_res_valid && i_res_ready) r_res_valid <= 1'b0;
            if (i_drain) r_drain_cnt <= DRAIN_LOAD;

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (!i_wb_we) begin
                            r_wb_ack   <= 1'b1;
                            r_fetch_pc <= i_wb_adr;
                            r_state    <= ST_ACK;
                            if (w_serve_inst) begin
                                r_wb_dat <= fetch_line(w_head, NOP_INST);
                            end else if (!i_drain && r_drain_cnt != 8'd0) begin
                                r_drain_cnt <= r_drain_cnt - 8'd1;
                            end
                        end else if (i_wb_sel == '0) begin
                            r_wb_err <= 1'b1;
                            r_state  <= ST_ACK;
                        end else if (!r_res_valid) begin
                            r_wb_ack    <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_res_adr   <= i_wb_adr;
                            r_res_sel   <= i_wb_sel;
                            r_res_data  <= i_wb_dat;
                            r_state     <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT_RES;
                        end
                    end else if (i_drain) begin
                        r_state <= ST_DRAIN_CHK;
                    end
                end
                ST_WAIT_RES: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (!r_res_valid) begin
                        r_wb_ack    <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_res_adr   <= i_wb_adr;
                        r_res_sel   <= i_wb_sel;
                        r_res_data  <= i_wb_dat;
                        r_state     <= ST_ACK;
                    end
                end
                ST_ACK, ST_DRAIN_CHK: r_state <= ST_IDLE;
                default:              r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_inst_ready = !w_fifo_full;
    assign o_wb_ack     = r_wb_ack;
    assign o_wb_err     = r_wb_err;
    assign o_wb_dat     = r_wb_dat;
    assign o_res_valid  = r_res_valid;
    assign o_res_adr    = r_res_adr;
    assign o_res_sel    = r_res_sel;
    assign o_res_data   = r_res_data;
    assign o_fetch_pc   = r_fetch_pc;
    assign o_busy       = (w_count != '0) || (r_drain_cnt != 8'd0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_inst_sequencer.sv
// Directed bench for wb_inst_sequencer: read vector table plus hand sequences for full, stall, drain and reset.
module tb_wb_inst_sequencer;

    localparam logic [31:0]  NOP      = 32'hF0801003;
    localparam logic [127:0] NOP_LINE = {NOP, NOP, NOP, NOP};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inst_valid;
    logic [31:0]  inst;
    logic         inst_ready;
    logic         wb_cyc, wb_stb, wb_we;
    logic [31:0]  wb_adr;
    logic [15:0]  wb_sel;
    logic [127:0] wb_dat_w;
    logic [127:0] wb_dat_r;
    logic         wb_ack, wb_err;
    logic         res_valid, res_ready;
    logic [31:0]  res_adr;
    logic [15:0]  res_sel;
    logic [127:0] res_data;
    logic         drain;
    logic         busy;
    logic [31:0]  fetch_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_inst_sequencer #(
        .FIFO_DEPTH (4),
        .NOP_INST   (32'hF0801003),
        .DRAIN_NOPS (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inst_valid (inst_valid),
        .i_inst       (inst),
        .o_inst_ready (inst_ready),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .i_wb_we      (wb_we),
        .i_wb_adr     (wb_adr),
        .i_wb_sel     (wb_sel),
        .i_wb_dat     (wb_dat_w),
        .o_wb_dat     (wb_dat_r),
        .o_wb_ack     (wb_ack),
        .o_wb_err     (wb_err),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_adr    (res_adr),
        .o_res_sel    (res_sel),
        .o_res_data   (res_data),
        .i_drain      (drain),
        .o_busy       (busy),
        .o_fetch_pc   (fetch_pc)
    );

    typedef struct {
        int          n_push;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] adr;
        logic [31:0] exp_word;
        logic        exp_busy;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] word);
        inst_valid = 1'b1;
        inst       = word;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wait_resp(input int maxc, output logic got_ack, output logic got_err, output int n);
        got_ack = 1'b0;
        got_err = 1'b0;
        n       = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (wb_ack || wb_err) begin
                got_ack = wb_ack;
                got_err = wb_err;
                n       = i;
                break;
            end
        end
    endtask

    task automatic do_read(input logic [31:0] adr, output logic [127:0] dat, output int lat);
        logic a, e;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = adr;
        wait_resp(6, a, e, lat);
        dat = wb_dat_r;
        if (!a) lat = 0;
        bus_idle();
    endtask

    task automatic start_write(input logic [31:0] adr, input logic [15:0] sel, input logic [127:0] dat);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = 1'b1;
        wb_adr   = adr;
        wb_sel   = sel;
        wb_dat_w = dat;
    endtask

    initial begin : main
        logic [127:0] d;
        int           lat, n;
        logic         ga, ge;

        rst_n = 1'b0; inst_valid = 1'b0; inst = '0; bus_idle();
        wb_adr = '0; wb_sel = '0; wb_dat_w = '0; res_ready = 1'b0; drain = 1'b0;

        vecs[0] = '{1, 32'hE3A01005, 32'h0,        32'h100, 32'hE3A01005, 1'b0};
        vecs[1] = '{0, 32'h0,        32'h0,        32'h104, NOP,          1'b0};
        vecs[2] = '{1, 32'h11111111, 32'h0,        32'h108, 32'h11111111, 1'b0};
        vecs[3] = '{2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h200, 32'hA5A5A5A5, 1'b1};
        vecs[4] = '{0, 32'h0,        32'h0,        32'h204, 32'h5A5A5A5A, 1'b0};
        vecs[5] = '{0, 32'h0,        32'h0,        32'h208, NOP,          1'b0};

        repeat (3) step();
        chk("rst_ready", inst_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", wb_ack, 1'b0);
        chk("rst_dat", wb_dat_r, NOP_LINE);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].n_push > 0) push(vecs[v].w0);
            if (vecs[v].n_push > 1) push(vecs[v].w1);
            do_read(vecs[v].adr, d, lat);
            chk($sformatf("vec%0d_lat", v), 128'(lat), 128'd1);
            chk($sformatf("vec%0d_dat", v), d, {NOP, NOP, NOP, vecs[v].exp_word});
            chk($sformatf("vec%0d_pc", v), fetch_pc, vecs[v].adr);
            step();
            chk($sformatf("vec%0d_ack_low", v), wb_ack, 1'b0);
            chk($sformatf("vec%0d_dat_idle", v), wb_dat_r, NOP_LINE);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
        end

        // Fill the queue, hold a fifth push, then drain it in order.
        for (int i = 0; i < 4; i++) push(32'hA0000000 + 32'(i));
        chk("full_ready", inst_ready, 1'b0);
        inst_valid = 1'b1;
        inst       = 32'hA0000004;
        step(); step();
        chk("full_hold_ready", inst_ready, 1'b0);
        do_read(32'h300, d, lat);
        chk("full_rd0_lat", 128'(lat), 128'd1);
        chk("full_rd0", d, {NOP, NOP, NOP, 32'hA0000000});
        step();
        inst_valid = 1'b0;
        chk("full_again", inst_ready, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            do_read(32'h300 + 32'(4*j), d, lat);
            chk($sformatf("full_rd%0d", j), d, {NOP, NOP, NOP, 32'hA0000000 + 32'(j)});
            step();
        end
        chk("full_busy_end", busy, 1'b0);

        // Result slot: first write captured, second stalls until the slot frees.
        res_ready = 1'b0;
        start_write(32'h200, 16'hFFFF, {96'h0, 32'hDEADBEEF});
        wait_resp(6, ga, ge, n);
        chk("wr1_ack", ga, 1'b1);
        chk("wr1_lat", 128'(n), 128'd1);
        chk("wr1_valid", res_valid, 1'b1);
        chk("wr1_adr", res_adr, 32'h200);
        chk("wr1_sel", res_sel, 16'hFFFF);
        chk("wr1_data", res_data, {96'h0, 32'hDEADBEEF});
        bus_idle();
        step();
        start_write(32'h300, 16'h00FF, 128'h1234_5678);
        wait_resp(4, ga, ge, n);
        chk("wr2_stall", ga, 1'b0);
        chk("wr2_stall_adr", res_adr, 32'h200);
        chk("wr2_stall_busy", busy, 1'b1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("wr2_slot_free", res_valid, 1'b0);
        wait_resp(4, ga, ge, n);
        chk("wr2_ack", ga, 1'b1);
        chk("wr2_lat", 128'(n), 128'd1);
        chk("wr2_adr", res_adr, 32'h300);
        chk("wr2_sel", res_sel, 16'h00FF);
        chk("wr2_data", res_data, 128'h1234_5678);
        bus_idle();
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("wr2_consumed", res_valid, 1'b0);

        // Drain: eight NOP fetches before queued instructions resume.
        push(32'hC0000001);
        push(32'hC0000002);
        drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        chk("drain_busy", busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            do_read(32'h400 + 32'(4*k), d, lat);
            chk($sformatf("drain_nop%0d", k), d, NOP_LINE);
            step();
        end
        do_read(32'h420, d, lat);
        chk("drain_inst0", d, {NOP, NOP, NOP, 32'hC0000001});
        step();
        do_read(32'h424, d, lat);
        chk("drain_inst1", d, {NOP, NOP, NOP, 32'hC0000002});
        chk("drain_pc", fetch_pc, 32'h424);
        step();
        chk("drain_busy_end", busy, 1'b0);

        start_write(32'h600, 16'h0000, 128'hBAD);
        wait_resp(4, ga, ge, n);
        chk("err_pulse", ge, 1'b1);
        chk("err_no_ack", ga, 1'b0);
        chk("err_lat", 128'(n), 128'd1);
        chk("err_no_capture", res_valid, 1'b0);
        bus_idle();
        step();
        chk("err_one_cycle", wb_err, 1'b0);

        // Reset while a write waits for the result slot.
        start_write(32'h500, 16'h000F, 128'h55);
        wait_resp(4, ga, ge, n);
        chk("rw1_ack", ga, 1'b1);
        bus_idle();
        step();
        start_write(32'h504, 16'h000F, 128'h66);
        wait_resp(3, ga, ge, n);
        chk("rw2_stall", ga, 1'b0);
        rst_n = 1'b0;
        bus_idle();
        #1;
        chk("mid_rst_ack", wb_ack, 1'b0);
        chk("mid_rst_err", wb_err, 1'b0);
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_adr", res_adr, 32'h0);
        chk("mid_rst_data", res_data, 128'h0);
        chk("mid_rst_pc", fetch_pc, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", inst_ready, 1'b1);
        step(); step();
        rst_n = 1'b1;
        wait_resp(5, ga, ge, n);
        chk("post_rst_no_ack", ga, 1'b0);
        chk("post_rst_no_err", ge, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
